controller_standby_mux: RTL and testbench

- Parametrised N-engine front end for the standby controller.
- Arbitrates which target engine (I2C, I3C, or a future HDR/recovery engine) owns the shared TTI RX queues. Only one engine is enabled at a time.
- Engine changes are deferred until the bus is idle. On each change the block flushes the queues, so data from two engines is never interleaved.
- Collects sticky per-engine error flags. Sits between the engine instances and the TTI queues.

---
 rtl/controller_standby_mux.sv | 154 +++++++++++++++
 tb/tb_controller_standby_mux.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/controller_standby_mux.sv
// rtl/controller_standby_mux.sv - N-engine owner arbitration and TTI RX queue mux for the standby controller
module controller_standby_mux #(
  parameter int NumEngines      = 2,
  parameter int ResetSel        = 0,
  parameter int RxDescDataWidth = 32,
  parameter int RxDataWidth     = 8,
  parameter int IdleCntWidth    = 20,
  localparam int SelW           = $clog2(NumEngines)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [SelW-1:0]                       mode_req_i,
  input  logic                                  mode_req_valid_i,
  input  logic [IdleCntWidth-1:0]               t_bus_idle_i,
  input  logic [NumEngines-1:0]                 eng_busy_i,
  output logic [NumEngines-1:0]                 eng_en_o,
  output logic [SelW-1:0]                       active_sel_o,
  output logic                                  switching_o,
  output logic                                  switch_done_o,
  output logic                                  switch_err_o,
  input  logic [NumEngines-1:0]                 eng_rx_desc_wvalid_i,
  input  logic [NumEngines*RxDescDataWidth-1:0] eng_rx_desc_wdata_i,
  output logic [NumEngines-1:0]                 eng_rx_desc_wready_o,
  output logic                                  rx_desc_wvalid_o,
  output logic [RxDescDataWidth-1:0]            rx_desc_wdata_o,
  input  logic                                  rx_desc_wready_i,
  input  logic [NumEngines-1:0]                 eng_rx_wvalid_i,
  input  logic [NumEngines*RxDataWidth-1:0]     eng_rx_wdata_i,
  output logic [NumEngines-1:0]                 eng_rx_wready_o,
  output logic                                  rx_wvalid_o,
  output logic [RxDataWidth-1:0]                rx_wdata_o,
  input  logic                                  rx_wready_i,
  output logic                                  rx_flush_o,
  output logic                                  tx_flush_o,
  input  logic [NumEngines-1:0]                 eng_err_i,
  input  logic                                  err_clear_i,
  output logic [NumEngines-1:0]                 err_src_o,
  output logic                                  err_o
);

  localparam logic [SelW-1:0] ResetSelL = SelW'(ResetSel);
  localparam int unsigned     NumEngU   = NumEngines;

  typedef enum logic [1:0] {StActive, StDrain, StIdleWait, StFlush} state_e;

  state_e                  state_q, state_d;
  logic [SelW-1:0]         sel_q, sel_d, tgt_q, tgt_d;
  logic [IdleCntWidth-1:0] cnt_q, cnt_d;
  logic                    done_q;
  logic [NumEngines-1:0]   err_q;
  logic                    req_diff, req_ok, cur_busy;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StActive;
      sel_q   <= ResetSelL;
      tgt_q   <= ResetSelL;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_q == StFlush);
      // A fresh error in the same cycle as a clear survives.
      err_q   <= (err_q & ~{NumEngines{err_clear_i}}) | eng_err_i;
    end
  end

  assign req_diff = mode_req_valid_i && (mode_req_i != sel_q);
  assign req_ok   = 32'(mode_req_i) < NumEngU;
  assign cur_busy = eng_busy_i[sel_q];

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    tgt_d        = tgt_q;
    cnt_d        = cnt_q;
    switch_err_o = 1'b0;
    case (state_q)
      StActive: begin
        if (req_diff) begin
          if (!req_ok) begin
            switch_err_o = 1'b1;
          end else begin
            tgt_d   = mode_req_i;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!req_diff) begin
          state_d = StActive;
        end else begin
          if (req_ok) tgt_d = mode_req_i;
          if (!cur_busy) begin
            state_d = StIdleWait;
            cnt_d   = '0;
          end
        end
      end
      StIdleWait: begin
        if (!req_diff) begin
          state_d = StActive;
        end else begin
          if (req_ok) tgt_d = mode_req_i;
          if (cur_busy) begin
            state_d = StDrain;
          end else if (cnt_q == t_bus_idle_i) begin
            state_d = StFlush;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFlush: begin
        sel_d   = tgt_q;
        state_d = StActive;
      end
      default: state_d = StActive;
    endcase
  end

  // Owner's queues pass straight through; everything is gated off during the flush cycle.
  always_comb begin
    eng_en_o             = '0;
    rx_desc_wvalid_o     = 1'b0;
    rx_desc_wdata_o      = '0;
    eng_rx_desc_wready_o = '0;
    rx_wvalid_o          = 1'b0;
    rx_wdata_o           = '0;
    eng_rx_wready_o      = '0;
    if (state_q != StFlush) begin
      eng_en_o[sel_q]             = 1'b1;
      rx_desc_wvalid_o            = eng_rx_desc_wvalid_i[sel_q];
      rx_desc_wdata_o             = eng_rx_desc_wdata_i[sel_q*RxDescDataWidth +: RxDescDataWidth];
      eng_rx_desc_wready_o[sel_q] = rx_desc_wready_i;
      rx_wvalid_o                 = eng_rx_wvalid_i[sel_q];
      rx_wdata_o                  = eng_rx_wdata_i[sel_q*RxDataWidth +: RxDataWidth];
      eng_rx_wready_o[sel_q]      = rx_wready_i;
    end
  end

  assign active_sel_o  = sel_q;
  assign switching_o   = (state_q != StActive);
  assign switch_done_o = done_q;
  assign rx_flush_o    = (state_q == StFlush);
  assign tx_flush_o    = (state_q == StFlush);
  assign err_src_o     = err_q;
  assign err_o         = |err_q;

endmodule

// File: tb/tb_controller_standby_mux.sv
// tb/tb_controller_standby_mux.sv - randomized bench for controller_standby_mux against a behavioural model
module tb_controller_standby_mux;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int CW = 20;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [1:0]      mode_req;
  logic            mode_req_valid;
  logic [CW-1:0]   t_bus_idle;
  logic [N-1:0]    eng_busy;
  logic [N-1:0]    eng_en;
  logic [1:0]      active_sel;
  logic            switching, switch_done, switch_err;
  logic [N-1:0]    eng_desc_v, eng_desc_r;
  logic [N*DW-1:0] eng_desc_d;
  logic            desc_v, desc_r;
  logic [DW-1:0]   desc_d;
  logic [N-1:0]    eng_rx_v, eng_rx_r;
  logic [N*BW-1:0] eng_rx_d;
  logic            rx_v, rx_r;
  logic [BW-1:0]   rx_d;
  logic            rx_flush, tx_flush;
  logic [N-1:0]    eng_err;
  logic            err_clear;
  logic [N-1:0]    err_src;
  logic            err_any;

  always #5 clk = ~clk;

  controller_standby_mux #(
    .NumEngines(N), .ResetSel(0), .RxDescDataWidth(DW), .RxDataWidth(BW), .IdleCntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .mode_req_i(mode_req), .mode_req_valid_i(mode_req_valid),
    .t_bus_idle_i(t_bus_idle), .eng_busy_i(eng_busy), .eng_en_o(eng_en), .active_sel_o(active_sel),
    .switching_o(switching), .switch_done_o(switch_done), .switch_err_o(switch_err),
    .eng_rx_desc_wvalid_i(eng_desc_v), .eng_rx_desc_wdata_i(eng_desc_d), .eng_rx_desc_wready_o(eng_desc_r),
    .rx_desc_wvalid_o(desc_v), .rx_desc_wdata_o(desc_d), .rx_desc_wready_i(desc_r),
    .eng_rx_wvalid_i(eng_rx_v), .eng_rx_wdata_i(eng_rx_d), .eng_rx_wready_o(eng_rx_r),
    .rx_wvalid_o(rx_v), .rx_wdata_o(rx_d), .rx_wready_i(rx_r),
    .rx_flush_o(rx_flush), .tx_flush_o(tx_flush),
    .eng_err_i(eng_err), .err_clear_i(err_clear), .err_src_o(err_src), .err_o(err_any)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: who owns the bus, whether a switch is pending, and how many quiet cycles have been seen.
  int         m_sel, m_tgt, m_quiet;
  bit         m_pend, m_flush, m_done;
  logic [2:0] m_err;

  task automatic model_step();
    bit         nd, want, inr;
    logic [2:0] ne;
    nd   = m_flush;
    ne   = (m_err & ~{3{err_clear}}) | eng_err;
    want = mode_req_valid && (int'(mode_req) != m_sel);
    inr  = int'(mode_req) < N;
    if (!rst_ni) begin
      m_sel = 0; m_tgt = 0; m_quiet = -1; m_pend = 0; m_flush = 0; m_done = 0; m_err = '0;
    end else begin
      if (m_flush) begin
        m_sel = m_tgt; m_flush = 0;
      end else if (!m_pend) begin
        if (want && inr) begin m_pend = 1; m_tgt = int'(mode_req); m_quiet = -1; end
      end else if (!want) begin
        m_pend = 0;
      end else begin
        if (inr) m_tgt = int'(mode_req);
        if (m_quiet < 0) begin
          if (!eng_busy[m_sel]) m_quiet = 0;
        end else if (eng_busy[m_sel]) begin
          m_quiet = -1;
        end else if (m_quiet == int'(t_bus_idle)) begin
          m_pend = 0; m_flush = 1;
        end else begin
          m_quiet++;
        end
      end
      m_done = nd;
      m_err  = ne;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] en_e, r_e;
    bit           serr_e;
    en_e   = m_flush ? '0 : 3'(1 << m_sel);
    r_e    = '0;
    serr_e = !m_pend && !m_flush && mode_req_valid && int'(mode_req) != m_sel && int'(mode_req) >= N;
    chk("eng_en", 64'(eng_en), 64'(en_e));
    chk("active_sel", 64'(active_sel), 64'(m_sel));
    chk("switching", 64'(switching), 64'(m_pend || m_flush));
    chk("switch_done", 64'(switch_done), 64'(m_done));
    chk("switch_err", 64'(switch_err), 64'(serr_e));
    chk("rx_flush", 64'(rx_flush), 64'(m_flush));
    chk("tx_flush", 64'(tx_flush), 64'(m_flush));
    chk("err_src", 64'(err_src), 64'(m_err));
    chk("err_o", 64'(err_any), 64'(|m_err));
    if (m_flush) begin
      chk("desc_v", 64'(desc_v), 0); chk("desc_d", 64'(desc_d), 0); chk("desc_r", 64'(eng_desc_r), 0);
      chk("rx_v", 64'(rx_v), 0);     chk("rx_d", 64'(rx_d), 0);     chk("rx_r", 64'(eng_rx_r), 0);
    end else begin
      chk("desc_v", 64'(desc_v), 64'(eng_desc_v[m_sel]));
      chk("desc_d", 64'(desc_d), 64'(eng_desc_d[m_sel*DW +: DW]));
      r_e[m_sel] = desc_r;
      chk("desc_r", 64'(eng_desc_r), 64'(r_e));
      chk("rx_v", 64'(rx_v), 64'(eng_rx_v[m_sel]));
      chk("rx_d", 64'(rx_d), 64'(eng_rx_d[m_sel*BW +: BW]));
      r_e = '0; r_e[m_sel] = rx_r;
      chk("rx_r", 64'(eng_rx_r), 64'(r_e));
    end
  endtask

  // Called at posedge+1 with fresh inputs; returns at the next posedge+1.
  task automatic step();
    #4;
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    int cnt;
    bit seen;
    rst_ni = 0; mode_req = 0; mode_req_valid = 0; t_bus_idle = 4; eng_busy = 0;
    eng_desc_v = 0; eng_desc_d = 0; desc_r = 0; eng_rx_v = 0; eng_rx_d = 0; rx_r = 0;
    eng_err = 0; err_clear = 0;
    m_sel = 0; m_tgt = 0; m_quiet = -1; m_pend = 0; m_flush = 0; m_done = 0; m_err = '0;
    @(posedge clk); model_step(); #1;
    step(); step();
    rst_ni = 1;
    step();
    chk("rst_eng_en", 64'(eng_en), 64'(3'b001));
    chk("rst_sel", 64'(active_sel), 0);
    chk("rst_switching", 64'(switching), 0);
    chk("rst_err", 64'(err_any), 0);

    // Clean switch to engine 1 with a 4-cycle idle requirement.
    mode_req = 1; mode_req_valid = 1; t_bus_idle = 4; eng_busy = 0;
    cnt = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (rx_flush) seen = 1;
      else if (switching) cnt++;
    end
    chk("flush_seen", 64'(seen), 1);
    chk("pre_flush_cycles", 64'(cnt), 6);
    chk("flush_eng_en", 64'(eng_en), 0);
    step();
    chk("new_sel", 64'(active_sel), 1);
    chk("new_eng_en", 64'(eng_en), 64'(3'b010));
    chk("done_pulse", 64'(switch_done), 1);
    step();
    chk("done_single", 64'(switch_done), 0);

    // Busy bounces during the idle wait, so the count restarts.
    mode_req = 0; eng_busy = 3'b010;
    repeat (3) step();
    eng_busy = 0;
    repeat (3) step();
    eng_busy = 3'b010;
    step();
    chk("bounce_switching", 64'(switching), 1);
    eng_busy = 0;
    cnt = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(); cnt++;
      if (rx_flush) seen = 1;
    end
    chk("bounce_flush_seen", 64'(seen), 1);
    chk("bounce_flush_delay", 64'(cnt), 6);
    step();
    chk("bounce_sel", 64'(active_sel), 0);

    // Out-of-range request, then a withdrawn in-range request.
    mode_req = 3; mode_req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("oor_err", 64'(switch_err), 1);
      chk("oor_en", 64'(eng_en), 64'(3'b001));
      step();
    end
    mode_req = 2; t_bus_idle = 10;
    repeat (4) step();
    mode_req_valid = 0;
    step();
    chk("withdraw_switching", 64'(switching), 0);
    chk("withdraw_sel", 64'(active_sel), 0);

    // Stream mux: engine 0 owns, engine 1 is ignored.
    eng_rx_v = 3'b011; eng_rx_d = {8'h00, 8'h77, 8'hA5}; rx_r = 0;
    #1 chk("mux_d0", 64'(rx_d), 64'h A5);
    chk("mux_r_idle", 64'(eng_rx_r), 0);
    step();
    rx_r = 1; eng_rx_d = {8'h00, 8'h77, 8'h5A};
    #1 chk("mux_d1", 64'(rx_d), 64'h5A);
    chk("mux_r_go", 64'(eng_rx_r), 64'(3'b001));
    step();
    eng_rx_v = 0; rx_r = 0;

    // Sticky errors: set beats clear, then clear alone.
    eng_err = 3'b010; err_clear = 1;
    step();
    eng_err = 0;
    chk("err_set_wins", 64'(err_src), 64'(3'b010));
    step();
    err_clear = 0;
    chk("err_cleared", 64'(err_src), 0);
    chk("err_o_cleared", 64'(err_any), 0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) mode_req = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) mode_req_valid = ~mode_req_valid;
      if ($urandom_range(40) == 0) t_bus_idle = CW'($urandom_range(5));
      if ($urandom_range(3) == 0) eng_busy = 3'($urandom);
      eng_desc_v = 3'($urandom); eng_desc_d = {$urandom, $urandom, $urandom};
      eng_rx_v = 3'($urandom);   eng_rx_d = 24'($urandom);
      desc_r = 1'($urandom); rx_r = 1'($urandom);
      eng_err = ($urandom_range(9) == 0) ? 3'($urandom) : 3'b000;
      err_clear = ($urandom_range(15) == 0);
      rst_ni = ($urandom_range(199) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
